router_input_arbiter: RTL and testbench

ROUTER_INPUT_ARBITER -- requirements
Module: router_input_arbiter

---
 rtl/router_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/router_input_arbiter.sv | 145 ++++++++++++++
 tb/tb_router_input_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg
// Shared definitions for the router input arbiter: FSM state encoding,
// beat field widths and the default idle timeout.
package router_pkg;

    // Arbiter FSM: IDLE picks a new owner, LOCKED forwards that owner's packet.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam int PAYLOAD_W       = 8;
    localparam int ADDR_W          = 2;
    localparam int TYPE_W          = 2;
    localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin priority pick. The search starts at ptr and
// walks upward, wrapping past NUM_REQ-1 back to 0 (NUM_REQ is a power of
// two, so the wrap is plain index overflow).
// Ports:
//   req     - request vector
//   ptr     - index with highest priority this cycle
//   gnt     - one-hot grant (all zero when nothing requests)
//   gnt_idx - index of the granted requester (0 when nothing requests)
//   any_gnt - high when some requester was granted
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       any_gnt
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // Priority scan from ptr upward; the first requesting index wins.
    always_comb begin
        cand_s  = '0;
        hit_s   = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s  = ptr + IDX_W'(i);
            hit_s   = req[cand_s] & ~any_gnt;
            gnt_idx = hit_s ? cand_s : gnt_idx;
            any_gnt = any_gnt | hit_s;
        end
        gnt[gnt_idx] = any_gnt;
    end

endmodule

// File: rtl/router_input_arbiter.sv
// router_input_arbiter
// Shares one router input among NUM_REQ requesters. A round-robin winner is
// registered in IDLE and owns the output until its end-of-packet beat
// transfers, or until its valid stays low for TIMEOUT consecutive cycles.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   req_valid/req_eop     - per-requester beat valid / end-of-packet
//   req_dest_addr/req_packet_type/req_payload - per-requester beat fields (packed)
//   req_ready             - per-requester beat accept
//   out_valid/out_*/out_ready - beat toward the router
//   grant_id              - current (or last) owner index
//   busy                  - grant held
//   timeout_err           - one-cycle pulse when a grant is revoked by timeout
module router_input_arbiter
    import router_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_dest_addr,
    input  logic [NUM_REQ*TYPE_W-1:0]    req_packet_type,
    input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload,
    input  logic [NUM_REQ-1:0]           req_eop,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         out_valid,
    output logic [ADDR_W-1:0]            out_dest_addr,
    output logic [TYPE_W-1:0]            out_packet_type,
    output logic [PAYLOAD_W-1:0]         out_payload,
    output logic                         out_eop,
    input  logic                         out_ready,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Count value on the last tolerated idle cycle; one more idle cycle revokes.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [IDX_W-1:0]   grant_id_r;
    logic [NUM_REQ-1:0] grant_oh_r;
    logic [CNT_W-1:0]   idle_cnt_r;
    logic               timeout_err_r;

    logic [NUM_REQ-1:0] arb_gnt_s;
    logic [IDX_W-1:0]   arb_idx_s;
    logic               arb_any_s;
    logic               owner_valid_s;
    logic               owner_eop_s;
    logic               xfer_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr_r),
        .gnt     (arb_gnt_s),
        .gnt_idx (arb_idx_s),
        .any_gnt (arb_any_s)
    );

    assign owner_valid_s = req_valid[grant_id_r];
    assign owner_eop_s   = req_eop[grant_id_r];

    assign grant_id    = grant_id_r;
    assign busy        = (state_r == ST_LOCKED);
    assign timeout_err = timeout_err_r;

    // Output beat mux: only the locked owner reaches the router; IDLE forces
    // everything low so a new request never leaks straight through.
    always_comb begin
        out_valid       = 1'b0;
        out_dest_addr   = '0;
        out_packet_type = '0;
        out_payload     = '0;
        out_eop         = 1'b0;
        req_ready       = '0;
        xfer_s          = 1'b0;
        if (state_r == ST_LOCKED) begin
            out_valid       = owner_valid_s;
            out_dest_addr   = req_dest_addr[grant_id_r*ADDR_W +: ADDR_W];
            out_packet_type = req_packet_type[grant_id_r*TYPE_W +: TYPE_W];
            out_payload     = req_payload[grant_id_r*PAYLOAD_W +: PAYLOAD_W];
            out_eop         = owner_eop_s;
            req_ready       = grant_oh_r & {NUM_REQ{out_ready}};
            xfer_s          = owner_valid_s & out_ready;
        end else begin
            out_valid = 1'b0;
            req_ready = '0;
        end
    end

    // Grant FSM, round-robin pointer and idle-timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            rr_ptr_r      <= '0;
            grant_id_r    <= '0;
            grant_oh_r    <= '0;
            idle_cnt_r    <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            timeout_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    idle_cnt_r <= '0;
                    if (arb_any_s) begin
                        state_r    <= ST_LOCKED;
                        grant_id_r <= arb_idx_s;
                        grant_oh_r <= arb_gnt_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (xfer_s && owner_eop_s) begin
                        state_r    <= ST_IDLE;
                        rr_ptr_r   <= grant_id_r + IDX_W'(1);
                        idle_cnt_r <= '0;
                    end else if (owner_valid_s) begin
                        // Owner is present (possibly stalled by out_ready): not idle.
                        idle_cnt_r <= '0;
                    end else if (idle_cnt_r == CNT_LAST) begin
                        state_r       <= ST_IDLE;
                        rr_ptr_r      <= grant_id_r + IDX_W'(1);
                        idle_cnt_r    <= '0;
                        timeout_err_r <= 1'b1;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_input_arbiter.sv
// tb_router_input_arbiter
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural ownership model (owner index, priority pointer, idle count).
module tb_router_input_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [7:0]   req_dest_addr;
    logic [7:0]   req_packet_type;
    logic [31:0]  req_payload;
    logic [3:0]   req_eop;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [1:0]   out_dest_addr;
    logic [1:0]   out_packet_type;
    logic [7:0]   out_payload;
    logic         out_eop;
    logic         out_ready;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout_err;

    router_input_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_dest_addr   (req_dest_addr),
        .req_packet_type (req_packet_type),
        .req_payload     (req_payload),
        .req_eop         (req_eop),
        .req_ready       (req_ready),
        .out_valid       (out_valid),
        .out_dest_addr   (out_dest_addr),
        .out_packet_type (out_packet_type),
        .out_payload     (out_payload),
        .out_eop         (out_eop),
        .out_ready       (out_ready),
        .grant_id        (grant_id),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who owns the input (-1 = nobody), last granted index,
    // index with top priority, consecutive idle cycles, timeout pulse.
    int m_owner = -1;
    int m_gid   = 0;
    int m_ptr   = 0;
    int m_idle  = 0;
    bit m_terr  = 1'b0;

    // Snapshot of the last sampled cycle, and model-predicted accepted beats.
    logic       s_busy, s_ov, s_terr;
    logic [1:0] s_gid;
    logic [7:0] s_pay;
    logic [3:0] s_rdy;
    logic [3:0] acc;

    // Packet sources for directed phases.
    int         src_len  [4];
    int         src_beat [4];
    logic [7:0] src_base [4];
    logic [3:0] mute;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_advance();
        if (reset) begin
            m_owner = -1; m_gid = 0; m_ptr = 0; m_idle = 0; m_terr = 1'b0;
        end else begin
            m_terr = 1'b0;
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (req_valid[c]) begin
                        m_owner = c; m_gid = c; m_idle = 0;
                        break;
                    end
                end
            end else if (req_valid[m_owner] && out_ready && req_eop[m_owner]) begin
                m_ptr = (m_gid + 1) % N;
                m_owner = -1;
            end else if (req_valid[m_owner]) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle >= TO) begin
                    m_ptr = (m_gid + 1) % N;
                    m_owner = -1;
                    m_terr = 1'b1;
                    m_idle = 0;
                end
            end
        end
    endtask

    // Inputs are already driven; sample, compare, then clock the model.
    task automatic run_cycle();
        logic       e_busy, e_ov;
        logic [3:0] e_rdy;
        #2;
        e_busy = (m_owner >= 0);
        e_ov   = e_busy && req_valid[m_owner];
        e_rdy  = (e_busy && out_ready) ? (4'b0001 << m_owner) : 4'b0000;
        chk("busy",        32'(busy),        32'(e_busy));
        chk("out_valid",   32'(out_valid),   32'(e_ov));
        chk("req_ready",   32'(req_ready),   32'(e_rdy));
        chk("grant_id",    32'(grant_id),    32'(m_gid));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        if (e_ov) begin
            chk("out_payload", 32'(out_payload),     32'(req_payload[m_owner*8 +: 8]));
            chk("out_dest",    32'(out_dest_addr),   32'(req_dest_addr[m_owner*2 +: 2]));
            chk("out_type",    32'(out_packet_type), 32'(req_packet_type[m_owner*2 +: 2]));
            chk("out_eop",     32'(out_eop),         32'(req_eop[m_owner]));
        end
        s_busy = busy; s_ov = out_valid; s_terr = timeout_err;
        s_gid = grant_id; s_pay = out_payload; s_rdy = req_ready;
        acc = e_rdy & req_valid;
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0; src_beat[i] = 0; src_base[i] = 8'h00;
        end
        mute = 4'b0000;
    endtask

    task automatic src_cycle();
        for (int i = 0; i < N; i++) begin
            if (src_beat[i] < src_len[i] && !mute[i]) begin
                req_valid[i] = 1'b1;
                req_eop[i]   = (src_beat[i] == src_len[i] - 1);
                req_payload[i*8 +: 8]     = src_base[i] + 8'(src_beat[i]);
                req_dest_addr[i*2 +: 2]   = 2'(i);
                req_packet_type[i*2 +: 2] = 2'(src_beat[i]);
            end else begin
                req_valid[i] = 1'b0;
                req_eop[i]   = 1'b0;
            end
        end
        run_cycle();
        for (int i = 0; i < N; i++) begin
            if (acc[i]) src_beat[i]++;
        end
    endtask

    int gq[$];
    int terr_cnt;
    int pct [4];

    initial begin
        reset = 1'b1; req_valid = 4'h0; req_eop = 4'h0; req_payload = 32'h0;
        req_dest_addr = 8'h0; req_packet_type = 8'h0; out_ready = 1'b1;
        clear_src();
        @(posedge clk); #1;
        run_cycle();
        reset = 1'b0;
        chk("rst_busy",   32'(s_busy), 32'd0);
        chk("rst_ovalid", 32'(s_ov),   32'd0);
        chk("rst_ready",  32'(s_rdy),  32'd0);
        chk("rst_gid",    32'(s_gid),  32'd0);

        // Requester 2 alone, 3-beat packet.
        src_len[2] = 3; src_base[2] = 8'hA0;
        for (int c = 0; c < 5; c++) begin
            src_cycle();
            if (c == 0 || c == 4) chk("r2_idle_busy", 32'(s_busy), 32'd0);
            if (c >= 1 && c <= 3) begin
                chk("r2_gid", 32'(s_gid), 32'd2);
                chk("r2_pay", 32'(s_pay), 32'hA0 + 32'(c - 1));
            end
        end
        // Pointer now 3: requester 3 beats requester 0.
        clear_src();
        src_len[0] = 1; src_len[3] = 1;
        for (int c = 0; c < 4; c++) begin
            src_cycle();
            if (c == 1) chk("ptr3_gid", 32'(s_gid), 32'd3);
            if (c == 3) chk("ptr3_next_gid", 32'(s_gid), 32'd0);
        end

        // All four offer 1-beat packets continuously (pointer reset to 0 first).
        clear_src();
        reset = 1'b1; src_cycle(); reset = 1'b0;
        req_valid = 4'hF; req_eop = 4'hF;
        gq.delete();
        for (int c = 0; c < 10; c++) begin
            run_cycle();
            chk("rr_busy_alt", 32'(s_busy), 32'(c % 2));
            if (s_busy) gq.push_back(int'(s_gid));
        end
        chk("rr_ngrants", 32'(gq.size()), 32'd5);
        for (int k = 0; k < 5 && k < gq.size(); k++) chk("rr_order", 32'(gq[k]), 32'(k % 4));
        req_valid = 4'h0; req_eop = 4'h0;
        run_cycle();

        // Requester 0 mid-packet while requester 1 raises valid (pointer is 1).
        clear_src();
        src_len[0] = 4; src_base[0] = 8'h10;
        gq.delete();
        for (int c = 0; c < 10; c++) begin
            if (c == 2) begin src_len[1] = 1; src_base[1] = 8'h20; end
            src_cycle();
            if (s_busy) gq.push_back(int'(s_gid));
        end
        chk("hold_ngrants", 32'(gq.size()), 32'd5);
        for (int k = 0; k < 5 && k < gq.size(); k++) chk("hold_gid", 32'(gq[k]), (k < 4) ? 32'd0 : 32'd1);

        // out_ready low 5 cycles mid-packet (pointer is 2).
        clear_src();
        src_len[2] = 4; src_base[2] = 8'h50;
        for (int c = 0; c < 10; c++) begin
            out_ready = !(c >= 2 && c <= 6);
            src_cycle();
            if (c >= 2 && c <= 6) begin
                chk("stall_pay",  32'(s_pay),  32'h51);
                chk("stall_ov",   32'(s_ov),   32'd1);
                chk("stall_rdy",  32'(s_rdy),  32'd0);
                chk("stall_terr", 32'(s_terr), 32'd0);
            end
        end
        chk("stall_done", 32'(src_beat[2]), 32'd4);
        out_ready = 1'b1;

        // Owner 3 goes silent for TIMEOUT cycles; requester 0 waits.
        clear_src();
        src_len[3] = 4; src_base[3] = 8'h30; src_len[0] = 1; src_base[0] = 8'h40;
        terr_cnt = 0;
        for (int c = 0; c < 21; c++) begin
            mute[3] = (c >= 2);
            if (c == 18) src_len[3] = 0;
            src_cycle();
            if (s_terr) terr_cnt++;
            if (c == 1)  chk("to_gid3", 32'(s_gid), 32'd3);
            if (c == 17) chk("to_still_busy", 32'(s_busy), 32'd1);
            if (c == 18) begin
                chk("to_pulse", 32'(s_terr), 32'd1);
                chk("to_idle",  32'(s_busy), 32'd0);
            end
            if (c == 19) chk("to_next_gid", 32'(s_gid), 32'd0);
        end
        chk("to_pulse_count", 32'(terr_cnt), 32'd1);

        // Reset on beat 2 of 4 (pointer is 1 before reset).
        clear_src();
        src_len[1] = 4; src_base[1] = 8'h70;
        for (int c = 0; c < 6; c++) begin
            reset = (c == 2);
            if (c == 3) begin
                src_len[1] = 0; src_len[0] = 1; src_len[3] = 1;
            end
            src_cycle();
            if (c == 3) begin
                chk("rst_mid_busy", 32'(s_busy), 32'd0);
                chk("rst_mid_ov",   32'(s_ov),   32'd0);
                chk("rst_mid_terr", 32'(s_terr), 32'd0);
            end
            if (c == 4) chk("rst_mid_ptr0", 32'(s_gid), 32'd0);
        end
        reset = 1'b0;

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                for (int i = 0; i < N; i++) begin
                    case ($urandom_range(0, 3))
                        0: pct[i] = 0;
                        1: pct[i] = 10;
                        2: pct[i] = 60;
                        default: pct[i] = 95;
                    endcase
                end
            end
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 99) < pct[i]);
                req_eop[i]   = ($urandom_range(0, 2) == 0);
            end
            req_payload     = $urandom;
            req_dest_addr   = 8'($urandom);
            req_packet_type = 8'($urandom);
            out_ready       = ($urandom_range(0, 3) != 0);
            reset           = ($urandom_range(0, 499) == 0);
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
